// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: byte stream in from uart_rx, FWFT read port and status out.
// With UART_RX_FIFO_AF_EN defined the bus also carries Almost_Full.
// master: the uart_rx / consumer side; slave: the FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] Rx_Data;
    logic              Rx_Valid;
    logic              Rx_Err;
    logic              Rd_En;
    logic              Clr_Overrun;
    logic [DATA_W-1:0] Rd_Data;
    logic              Empty;
    logic              Full;
    logic [ADDR_W:0]   Count;
    logic              Overrun;
    logic [7:0]        Err_Cnt;
`ifdef UART_RX_FIFO_AF_EN
    logic              Almost_Full;

    modport master (
        output Rx_Data, Rx_Valid, Rx_Err, Rd_En, Clr_Overrun,
        input  Rd_Data, Empty, Full, Count, Overrun, Err_Cnt, Almost_Full
    );
    modport slave (
        input  Rx_Data, Rx_Valid, Rx_Err, Rd_En, Clr_Overrun,
        output Rd_Data, Empty, Full, Count, Overrun, Err_Cnt, Almost_Full
    );
`else
    modport master (
        output Rx_Data, Rx_Valid, Rx_Err, Rd_En, Clr_Overrun,
        input  Rd_Data, Empty, Full, Count, Overrun, Err_Cnt
    );
    modport slave (
        input  Rx_Data, Rx_Valid, Rx_Err, Rd_En, Clr_Overrun,
        output Rd_Data, Empty, Full, Count, Overrun, Err_Cnt
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer behind uart_rx. Drops framing-error frames (counted,
// saturating at 255), stores good bytes in a DEPTH-entry FWFT FIFO, and raises a
// sticky Overrun when a good byte arrives while full with no pop in that cycle.
// Optional feature macro: UART_RX_FIFO_AF_EN (adds registered Almost_Full).
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    // Reject inconsistent geometry at elaboration.
    if (DEPTH != (1 << ADDR_W) || DEPTH < 2 || AF_LEVEL > DEPTH) begin : g_param_err
        $error("uart_rx_fifo: DEPTH must be 2**ADDR_W (>=2) and AF_LEVEL <= DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              overrun;
    logic [7:0]        err_cnt;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              good;
    logic              bad;
    logic              ovr_set;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign good    = bus.Rx_Valid & ~bus.Rx_Err;
    assign bad     = bus.Rx_Valid &  bus.Rx_Err;
    assign pop     = bus.Rd_En & ~empty;
    assign push    = good & (~full | pop);
    assign ovr_set = good & full & ~pop;

    // Next occupancy: push and pop in the same cycle cancel.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.Rx_Data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // Sticky overrun; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (bus.Clr_Overrun) begin
            overrun <= 1'b0;
        end
    end

    // Saturating count of dropped framing-error frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (bad && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    logic almost_full;

    // Registered threshold flag, tracking Count on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (count_nxt >= (ADDR_W+1)'(AF_LEVEL));
        end
    end

    assign bus.Almost_Full = almost_full;
`endif

    assign bus.Rd_Data = empty ? '0 : mem[rd_ptr];
    assign bus.Empty   = empty;
    assign bus.Full    = full;
    assign bus.Count   = count;
    assign bus.Overrun = overrun;
    assign bus.Err_Cnt = err_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
module tb_uart_rx_fifo;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DATA_W  (8),
        .DEPTH   (16),
        .ADDR_W  (4),
        .AF_LEVEL(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic drive(input logic valid, input logic err, input logic [7:0] data,
                         input logic rd, input logic clr);
        bus.Rx_Valid    = valid;
        bus.Rx_Err      = err;
        bus.Rx_Data     = data;
        bus.Rd_En       = rd;
        bus.Clr_Overrun = clr;
        @(posedge clk);
        #1;
        bus.Rx_Valid    = 1'b0;
        bus.Rx_Err      = 1'b0;
        bus.Rx_Data     = 8'h00;
        bus.Rd_En       = 1'b0;
        bus.Clr_Overrun = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        drive(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, 32'(bus.Rd_Data), 32'(exp));
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},   32'(bus.Empty),   32'd1);
        check({tag, "_full"},    32'(bus.Full),    32'd0);
        check({tag, "_count"},   32'(bus.Count),   32'd0);
        check({tag, "_rddata"},  32'(bus.Rd_Data), 32'd0);
        check({tag, "_overrun"}, 32'(bus.Overrun), 32'd0);
        check({tag, "_errcnt"},  32'(bus.Err_Cnt), 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b0;
        bus.Rx_Valid    = 1'b0;
        bus.Rx_Err      = 1'b0;
        bus.Rx_Data     = 8'h00;
        bus.Rd_En       = 1'b0;
        bus.Clr_Overrun = 1'b0;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Pop while empty is ignored
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_empty_count", 32'(bus.Count), 32'd0);
        check("pop_empty_flag",  32'(bus.Empty), 32'd1);

        // 2: two bytes
        push(8'hA5);
        check("t2_fwft_first", 32'(bus.Rd_Data), 32'hA5);
        check("t2_empty0",     32'(bus.Empty),   32'd0);
        push(8'h3C);
        check("t2_count2",     32'(bus.Count),   32'd2);
        check("t2_head",       32'(bus.Rd_Data), 32'hA5);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_head2",      32'(bus.Rd_Data), 32'h3C);
        check("t2_count1",     32'(bus.Count),   32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_empty",      32'(bus.Empty),   32'd1);
        check("t2_rd0",        32'(bus.Rd_Data), 32'd0);

        // 3: fill, overrun, drain, clear
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t3_full",    32'(bus.Full),    32'd1);
        check("t3_count16", 32'(bus.Count),   32'd16);
        check("t3_ovr0",    32'(bus.Overrun), 32'd0);
        push(8'hFF);
        check("t3_ovr1",    32'(bus.Overrun), 32'd1);
        check("t3_count",   32'(bus.Count),   32'd16);
        // set and clear in the same cycle: set wins
        drive(1'b1, 1'b0, 8'hFE, 1'b0, 1'b1);
        check("t3_ovr_setwins", 32'(bus.Overrun), 32'd1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("t3_pop%0d", i), 8'(i));
        check("t3_drained", 32'(bus.Empty),   32'd1);
        check("t3_ovr_kept",32'(bus.Overrun), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_ovr_clr", 32'(bus.Overrun), 32'd0);

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        drive(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        check("t4_count16", 32'(bus.Count),   32'd16);
        check("t4_ovr0",    32'(bus.Overrun), 32'd0);
        check("t4_full",    32'(bus.Full),    32'd1);
        for (int i = 1; i < 16; i++) pop_check($sformatf("t4_pop%0d", i), 8'h20 + 8'(i));
        pop_check("t4_last", 8'h77);
        check("t4_empty",   32'(bus.Empty),   32'd1);

        // 5: framing errors
        push(8'h11);
        push(8'h22);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("t5_err3",    32'(bus.Err_Cnt), 32'd3);
        check("t5_count",   32'(bus.Count),   32'd2);
        check("t5_ovr",     32'(bus.Overrun), 32'd0);
        pop_check("t5_pop0", 8'h11);
        pop_check("t5_pop1", 8'h22);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("t5_err_sat", 32'(bus.Err_Cnt), 32'd255);
        check("t5_empty",   32'(bus.Empty),   32'd1);

        // 6: pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) push(8'((r << 4) + i + 8'h80));
            check($sformatf("t6_count_r%0d", r), 32'(bus.Count), 32'd10);
            for (int i = 0; i < 10; i++)
                pop_check($sformatf("t6_r%0d_%0d", r, i), 8'((r << 4) + i + 8'h80));
        end
        check("t6_empty", 32'(bus.Empty), 32'd1);

`ifdef UART_RX_FIFO_AF_EN
        for (int i = 0; i < 11; i++) push(8'(i));
        check("af_11", 32'(bus.Almost_Full), 32'd0);
        push(8'h0B);
        check("af_12", 32'(bus.Almost_Full), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("af_pop11", 32'(bus.Almost_Full), 32'd0);
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("af_empty", 32'(bus.Empty), 32'd1);
`endif

        // 1b: asynchronous reset mid-stream with 5 bytes stored and Overrun set
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        push(8'hEE);
        check("r2_ovr_pre", 32'(bus.Overrun), 32'd1);
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("r2_count5",  32'(bus.Count),   32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("rst_mid");
`ifdef UART_RX_FIFO_AF_EN
        check("rst_mid_af", 32'(bus.Almost_Full), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(8'h99);
        check("post_rst_data",  32'(bus.Rd_Data), 32'h99);
        check("post_rst_count", 32'(bus.Count),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time bound in case the run stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
